// File: rtl/qa_strobe_sched.sv
// qa_strobe_sched: programmable strobe scheduler for the QA loopback path.
// Issues period-spaced strobes toward vita_tx_chain, forwards a delayed copy
// to qa_wrapper, tracks results in flight, and supports bursts, credit
// limiting, an output watchdog and a packed status word.
module qa_strobe_sched #(
    parameter logic [7:0] BASE  = 8'd0,
    parameter int         CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        run_tx,
    input  logic        dut_out_nd,
    output logic        strobe_tx,
    output logic        dut_nd,
    output logic [31:0] status,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STALL = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [CNT_W-1:0] INFL_MAX = '1;

    // configuration registers
    logic [15:0] period_r;
    logic        enable_r;
    logic [7:0]  max_infl_r;
    logic [15:0] burst_r;
    logic [15:0] timeout_r;

    // run-time state
    logic [2:0]       state, state_nxt;
    logic [15:0]      dcnt;
    logic [15:0]      sent;
    logic [15:0]      burst_cnt;
    logic [15:0]      wd_cnt;
    logic [CNT_W-1:0] inflight;
    logic             uflow;
    logic             tflag;

    logic        wr_period, wr_ctrl, wr_burst, wr_tmo, clr;
    logic [31:0] pend;
    logic        stall_cond, last_strobe, wd_trip;
    logic [7:0]  infl8;
    logic        unused_ok;

    assign wr_period = set_stb && (set_addr == BASE);
    assign wr_ctrl   = set_stb && (set_addr == BASE + 8'd1);
    assign wr_burst  = set_stb && (set_addr == BASE + 8'd2);
    assign wr_tmo    = set_stb && (set_addr == BASE + 8'd3);
    assign clr       = wr_ctrl && set_data[1];
    assign unused_ok = ^{set_data[31:16], set_data[7:2]};

    // A strobe in the clear cycle would land in a freshly zeroed counter, so it is masked.
    assign strobe_tx = (state == S_RUN) && (dcnt == 16'd0) && run_tx && !clr;

    // Credits count the strobe issuing now and the one whose dut_nd is still pending.
    assign pend        = 32'(inflight) + 32'(dut_nd) + 32'(strobe_tx);
    assign stall_cond  = (max_infl_r != 8'd0) && (pend >= 32'(max_infl_r));
    assign last_strobe = strobe_tx && (burst_r != 16'd0) &&
                         (17'(burst_cnt) + 17'd1 >= 17'(burst_r));
    assign wd_trip     = (timeout_r != 16'd0) && (inflight != '0) && !dut_out_nd &&
                         (17'(wd_cnt) + 17'd1 >= 17'(timeout_r));

    generate
        if (CNT_W >= 8) begin : g_infl_wide
            assign infl8 = inflight[7:0];
        end else begin : g_infl_narrow
            assign infl8 = {{(8-CNT_W){1'b0}}, inflight};
        end
    endgenerate

    assign status = {state, uflow, tflag, 3'b000, infl8, sent};
    assign busy   = (state == S_RUN) || (state == S_STALL) || (state == S_DRAIN);

    // Settings-bus register file; clear is decoded above and never stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_r   <= 16'd63;
            enable_r   <= 1'b1;
            max_infl_r <= 8'd0;
            burst_r    <= 16'd0;
            timeout_r  <= 16'd0;
        end else begin
            if (wr_period) period_r <= set_data[15:0];
            if (wr_ctrl) begin
                enable_r   <= set_data[0];
                max_infl_r <= set_data[15:8];
            end
            if (wr_burst) burst_r   <= set_data[15:0];
            if (wr_tmo)   timeout_r <= set_data[15:0];
        end
    end

    // Next-state: clear beats the watchdog, which beats the normal flow.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S_IDLE;
        end else if (wd_trip) begin
            state_nxt = S_ERR;
        end else begin
            case (state)
                S_IDLE:  if (enable_r) state_nxt = S_RUN;
                S_RUN: begin
                    if (!enable_r)        state_nxt = S_IDLE;
                    else if (last_strobe) state_nxt = S_DRAIN;
                    else if (stall_cond)  state_nxt = S_STALL;
                end
                S_STALL: begin
                    if (!enable_r)        state_nxt = S_IDLE;
                    else if (!stall_cond) state_nxt = S_RUN;
                end
                S_DRAIN: begin
                    if (!enable_r)                         state_nxt = S_IDLE;
                    else if ((inflight == '0) && !dut_nd)  state_nxt = S_DONE;
                end
                S_DONE:  if (!enable_r) state_nxt = S_IDLE;
                S_ERR:   state_nxt = S_ERR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register plus the sticky timeout flag raised on ERR entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            tflag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr)
                tflag <= 1'b0;
            else if ((state_nxt == S_ERR) && (state != S_ERR))
                tflag <= 1'b1;
        end
    end

    // Period downcounter: free-runs in RUN/STALL, reloads at zero or on clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dcnt <= 16'd63;
        else if (clr)
            dcnt <= period_r;
        else if ((state == S_RUN) || (state == S_STALL))
            dcnt <= (dcnt == 16'd0) ? period_r : dcnt - 16'd1;
    end

    // Strobe bookkeeping: sent total, burst progress and the delayed in_nd copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sent      <= 16'd0;
            burst_cnt <= 16'd0;
            dut_nd    <= 1'b0;
        end else begin
            dut_nd <= strobe_tx;
            if (clr)            sent <= 16'd0;
            else if (strobe_tx) sent <= sent + 16'd1;
            if (clr || (state == S_IDLE)) burst_cnt <= 16'd0;
            else if (strobe_tx)           burst_cnt <= burst_cnt + 16'd1;
        end
    end

    // In-flight tracker: saturating up, floor at zero with a sticky underflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
            uflow    <= 1'b0;
        end else if (clr) begin
            inflight <= '0;
            uflow    <= 1'b0;
        end else begin
            case ({dut_nd, dut_out_nd})
                2'b10: if (inflight != INFL_MAX) inflight <= inflight + 1'b1;
                2'b01: begin
                    if (inflight != '0) inflight <= inflight - 1'b1;
                    else                uflow    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Watchdog: counts result-less cycles while anything is outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wd_cnt <= 16'd0;
        else if (clr || dut_out_nd || (inflight == '0))
            wd_cnt <= 16'd0;
        else if (wd_cnt != 16'hFFFF)
            wd_cnt <= wd_cnt + 16'd1;
    end

endmodule

// File: tb/tb_qa_strobe_sched.sv
// Directed-random bench for qa_strobe_sched. Expected strobe times, states
// and counters are derived arithmetically from the programmed period, burst,
// credit limit and timeout; an echo queue plays the role of qa_wrapper.
module tb_qa_strobe_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic        run_tx = 1'b0;
    logic        dut_out_nd = 1'b0;
    logic        strobe_tx, dut_nd, busy;
    logic [31:0] status;

    localparam logic [7:0] BASE = 8'h10;
    localparam int HMAX = 20000;

    qa_strobe_sched #(.BASE(BASE), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .run_tx(run_tx), .dut_out_nd(dut_out_nd),
        .strobe_tx(strobe_tx), .dut_nd(dut_nd), .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stb_q[$];
    int nd_q[$];
    int echo_q[$];
    int exp_q[$];
    logic [2:0] st_hist [0:HMAX-1];
    logic       run_vec [0:HMAX-1];

    logic        w_stb = 1'b0;
    logic [7:0]  w_addr = 8'd0;
    logic [31:0] w_data = 32'd0;
    logic        man_out = 1'b0;
    int          echo_d = 0;
    int          rst_at = -1;

    logic        last_stb, last_nd, last_busy;
    logic [31:0] last_status;

    int P, B, D, M, TO, K, w, w2, s, r;
    logic [15:0] mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, sample just after.
    task automatic tick();
        logic echo_hit;
        @(negedge clk);
        set_stb  = w_stb;
        set_addr = w_addr;
        set_data = w_data;
        w_stb    = 1'b0;
        run_tx   = (cyc < HMAX) ? run_vec[cyc] : 1'b1;
        echo_hit = (echo_q.size() > 0) && (echo_q[0] == cyc);
        if (echo_hit) void'(echo_q.pop_front());
        dut_out_nd = man_out || echo_hit;
        man_out    = 1'b0;
        if (cyc == rst_at) reset_n = 1'b0;
        #1;
        last_stb    = strobe_tx;
        last_nd     = dut_nd;
        last_busy   = busy;
        last_status = status;
        if (cyc < HMAX) st_hist[cyc] = status[31:29];
        if (strobe_tx) stb_q.push_back(cyc);
        if (dut_nd) begin
            nd_q.push_back(cyc);
            if (echo_d > 0) echo_q.push_back(cyc + echo_d);
        end
        cyc++;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        w_stb  = 1'b1;
        w_addr = BASE + {6'd0, off};
        w_data = d;
        tick();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic flush();
        stb_q.delete();
        nd_q.delete();
        echo_q.delete();
    endtask

    function automatic logic [31:0] qat(input int q[$], input int i);
        return (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF;
    endfunction

    // dut_nd must follow every strobe by exactly one cycle.
    task automatic check_nd(input string tag);
        chk({tag, "_nd_cnt"}, 32'(nd_q.size()), 32'(stb_q.size()));
        for (int i = 0; i < stb_q.size() && i < nd_q.size(); i++)
            chk({tag, "_nd_lag"}, 32'(nd_q[i]), 32'(stb_q[i] + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < HMAX; i++) run_vec[i] = 1'b1;

        // ---- reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_strobe", 32'(strobe_tx), 32'd0);
        chk("rst_nd",     32'(dut_nd),    32'd0);
        chk("rst_status", status,         32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        #1 reset_n = 1'b1;

        // ---- 1: legacy cadence, one strobe every 64 cycles
        flush();
        run(200);
        chk("s1_count", 32'(stb_q.size()), 32'd3);
        chk("s1_first", qat(stb_q, 0), 32'd63);
        for (int i = 0; i + 1 < stb_q.size(); i++)
            chk("s1_space", 32'(stb_q[i+1] - stb_q[i]), 32'd64);
        check_nd("s1");
        chk("s1_state", 32'(st_hist[10]), 32'd1);

        // ---- 2: random period/burst with echoed results
        P = $urandom_range(0, 7);
        B = $urandom_range(1, 6);
        D = $urandom_range(1, 12);
        wr(2'd1, 32'd0);
        run(2);
        wr(2'd0, 32'(P));
        wr(2'd2, 32'(B));
        wr(2'd3, 32'd0);
        flush();
        echo_d = D;
        w = cyc;
        wr(2'd1, 32'd3);
        run(B * (P + 1) + D + 20);
        chk("s2_count", 32'(stb_q.size()), 32'(B));
        chk("s2_first", qat(stb_q, 0), 32'(w + 2 + P));
        for (int i = 0; i + 1 < stb_q.size(); i++)
            chk("s2_space", 32'(stb_q[i+1] - stb_q[i]), 32'(P + 1));
        check_nd("s2");
        if (stb_q.size() > 0)
            chk("s2_drain", 32'(st_hist[stb_q[stb_q.size()-1] + 1]), 32'd3);
        chk("s2_done",  32'(last_status[31:29]), 32'd4);
        chk("s2_sent",  32'(last_status[15:0]),  32'(B));
        chk("s2_infl",  32'(last_status[23:16]), 32'd0);
        chk("s2_busy",  32'(last_busy),          32'd0);

        // ---- 3: credit limit with no results returning
        M = $urandom_range(1, 4);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'd0);
        wr(2'd2, 32'd0);
        flush();
        echo_d = 0;
        wr(2'd1, (32'(M) << 8) | 32'd3);
        run(30);
        chk("s3_count", 32'(stb_q.size()), 32'(M));
        chk("s3_stall", 32'(last_status[31:29]), 32'd2);
        chk("s3_infl",  32'(last_status[23:16]), 32'(M));
        man_out = 1'b1;
        tick();
        run(20);
        chk("s3_count2", 32'(stb_q.size()), 32'(M + 1));
        chk("s3_stall2", 32'(last_status[31:29]), 32'd2);
        chk("s3_infl2",  32'(last_status[23:16]), 32'(M));
        chk("s3_uflow",  32'(last_status[28]),    32'd0);

        // ---- 4: watchdog trip, then clear recovers
        TO = $urandom_range(5, 30);
        P  = $urandom_range(1, 5);
        wr(2'd1, 32'd0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'(P));
        wr(2'd2, 32'd1);
        wr(2'd3, 32'(TO));
        flush();
        w = cyc;
        wr(2'd1, 32'd3);
        s = w + 2 + P;
        run_to(s + TO + 5);
        chk("s4_count", 32'(stb_q.size()), 32'd1);
        chk("s4_first", qat(stb_q, 0), 32'(s));
        chk("s4_pre",   32'(st_hist[s + 1 + TO]), 32'd3);
        chk("s4_err",   32'(st_hist[s + 2 + TO]), 32'd5);
        chk("s4_tflag", 32'(last_status[27]), 32'd1);
        chk("s4_busy",  32'(last_busy), 32'd0);
        w2 = cyc;
        wr(2'd1, 32'd3);
        run(2);
        chk("s4_idle",   32'(st_hist[w2 + 1]), 32'd0);
        chk("s4_run",    32'(st_hist[w2 + 2]), 32'd1);
        chk("s4_tclr",   32'(last_status[27]), 32'd0);
        chk("s4_sclr",   32'(last_status[15:0]), 32'd0);
        chk("s4_iclr",   32'(last_status[23:16]), 32'd0);

        // ---- 5: underflow, then coincident dut_nd/out_nd
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd2);
        run(2);
        man_out = 1'b1;
        tick();
        tick();
        chk("s5_uflow", 32'(last_status[28]), 32'd1);
        chk("s5_infl0", 32'(last_status[23:16]), 32'd0);
        P = $urandom_range(2, 6);
        wr(2'd0, 32'(P));
        wr(2'd2, 32'd0);
        flush();
        echo_d = 0;
        w = cyc;
        wr(2'd1, 32'd3);
        s = w + 2 + P;
        run_to(s + 1);
        man_out = 1'b1;
        run_to(s + 3);
        chk("s5_first",  qat(stb_q, 0), 32'(s));
        chk("s5_both",   32'(last_status[23:16]), 32'd0);
        chk("s5_uclr",   32'(last_status[28]), 32'd0);
        run_to(s + P + 4);
        chk("s5_inc",    32'(last_status[23:16]), 32'd1);

        // ---- 6: run_tx masking of slots, then async reset mid-RUN
        P = $urandom_range(2, 6);
        K = 10;
        mask = 16'($urandom);
        mask[1] = 1'b0;
        mask[2] = 1'b1;
        wr(2'd1, 32'd0);
        wr(2'd0, 32'(P));
        wr(2'd1, 32'd2);
        flush();
        echo_d = 1;
        exp_q.delete();
        w = cyc;
        for (int c = w; c < w + 4 + P + K * (P + 1); c++)
            run_vec[c] = 1'($urandom_range(0, 1));
        for (int k = 0; k < K; k++) begin
            run_vec[w + 2 + P + k * (P + 1)] = mask[k];
            if (mask[k]) exp_q.push_back(w + 2 + P + k * (P + 1));
        end
        wr(2'd1, 32'd3);
        run_to(w + 2 + P + (K - 1) * (P + 1) + 2);
        chk("s6_count", 32'(stb_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk("s6_slot", qat(stb_q, i), 32'(exp_q[i]));
        check_nd("s6");
        r = w + 2 + P + K * (P + 1);
        run_vec[r] = 1'b1;
        rst_at = r;
        run_to(r + 1);
        chk("s6_rst_stb",  32'(last_stb),  32'd0);
        chk("s6_rst_nd",   32'(last_nd),   32'd0);
        chk("s6_rst_stat", last_status,    32'd0);
        chk("s6_rst_busy", 32'(last_busy), 32'd0);
        chk("s6_rst_cnt",  32'(stb_q.size()), 32'(exp_q.size()));
        #2 reset_n = 1'b1;
        run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
